// File: rtl/toggle_cover_drain.sv
// toggle_cover_drain: records which per-bit cover points have been hit and
// streams the absolute index of each newly hit point over a valid/ready channel.
// Optional build macro TOGGLE_DRAIN_DEDUP_EN: when defined, each point is reported
// at most once between resets/clears; when undefined, every hit cycle pends the bit.
module toggle_cover_drain #(
   parameter int unsigned WIDTH       = 130,
   parameter int unsigned COVER_INDEX = 0,
   parameter int unsigned COVER_TOTAL = 38253,
   parameter int unsigned IDX_W       = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             valid,
   input  logic                         clear,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [IDX_W-1:0]             out_index,
   output logic [$clog2(WIDTH+1)-1:0]   covered_count,
   output logic                         all_covered,
   output logic                         busy
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // The absolute index range of this instance must fit inside the design total.
   if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
      $error("toggle_cover_drain: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
   end

   logic [WIDTH-1:0] covered;
   logic [WIDTH-1:0] pending;
   logic [WIDTH-1:0] fresh;
   logic [WIDTH-1:0] take;
   logic [WIDTH-1:0] low_onehot;
   logic [BW-1:0]    low_idx;
   logic             found;
   logic             stage_free;
   logic             load;
   logic [CW-1:0]    pop_count;

   // Decide which incoming hits become new reports.
   always_comb begin
`ifdef TOGGLE_DRAIN_DEDUP_EN
      fresh = valid & ~covered;
`else
      fresh = valid;
`endif
   end

   // Pick the lowest pending bit so same-cycle hits drain in ascending order.
   always_comb begin
      low_onehot = '0;
      low_idx    = '0;
      found      = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (pending[i] && !found) begin
            low_onehot[i] = 1'b1;
            low_idx       = BW'(i);
            found         = 1'b1;
         end
      end
   end

   // The holding register loads when it is empty or being drained; clear leaves it alone.
   always_comb begin
      stage_free = !out_valid || out_ready;
      load       = stage_free && found && !clear;
      take       = load ? low_onehot : '0;
   end

   // Population count of the covered bitmap, registered below.
   always_comb begin
      pop_count = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         pop_count = pop_count + CW'(covered[i]);
      end
   end

   // Coverage and pending bitmaps; clear restarts both from this cycle's hits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         covered <= '0;
         pending <= '0;
      end else if (clear) begin
         covered <= valid;
         pending <= valid;
      end else begin
         covered <= covered | valid;
         pending <= (pending & ~take) | fresh;
      end
   end

   // Output holding register: stays put while stalled, drops only after a transfer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_index <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_index <= IDX_W'(COVER_INDEX) + IDX_W'(low_idx);
      end else if (stage_free) begin
         out_valid <= 1'b0;
      end
   end

   // Registered covered count, one cycle behind the bitmap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         covered_count <= '0;
      end else begin
         covered_count <= pop_count;
      end
   end

   // Status outputs derived from registers only.
   always_comb begin
      all_covered = (covered_count == CW'(WIDTH));
      busy        = (pending != '0) || out_valid;
   end

endmodule

// File: tb/tb_toggle_cover_drain.sv
// Testbench for toggle_cover_drain: table-driven vectors plus hand-written
// sequences for repeat hits, clear, mid-operation reset and full coverage.
module tb_toggle_cover_drain;

   localparam int WIDTH = 130;
   localparam int BASE  = 1000;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] valid;
   logic             clear;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_index;
   logic [CW-1:0]    covered_count;
   logic             all_covered;
   logic             busy;

   int total = 0;
   int bad   = 0;
   logic [63:0] xfers[$];

   typedef struct {
      logic [WIDTH-1:0] vld;
      logic             rdy;
      logic             ov;
      logic [63:0]      idx;
      int               cnt;
      logic             bsy;
   } row_t;

   row_t tbl[11];

   toggle_cover_drain #(
      .WIDTH(WIDTH), .COVER_INDEX(BASE), .COVER_TOTAL(38253), .IDX_W(64)
   ) dut (
      .clock(clock), .reset(reset), .valid(valid), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
      .covered_count(covered_count), .all_covered(all_covered), .busy(busy)
   );

   // Free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Record every completed transfer.
   always @(posedge clock) begin
      if (reset && out_valid && out_ready) xfers.push_back(out_index);
   end

   function automatic logic [WIDTH-1:0] hit(input int k);
      logic [WIDTH-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] v, input logic rdy, input logic clr);
      valid     = v;
      out_ready = rdy;
      clear     = clr;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      int expCount;
      int orderBad;
      int budget;

      // Directed table: inputs for one cycle, outputs observed after that edge.
      tbl[0]  = '{vld: hit(5),                    rdy: 1'b1, ov: 1'b0, idx: 64'd0,    cnt: 0, bsy: 1'b1};
      tbl[1]  = '{vld: '0,                        rdy: 1'b1, ov: 1'b1, idx: 64'd1005, cnt: 1, bsy: 1'b1};
      tbl[2]  = '{vld: '0,                        rdy: 1'b1, ov: 1'b0, idx: 64'd0,    cnt: 1, bsy: 1'b0};
      tbl[3]  = '{vld: hit(0) | hit(64) | hit(129), rdy: 1'b0, ov: 1'b0, idx: 64'd0,  cnt: 1, bsy: 1'b1};
      tbl[4]  = '{vld: '0,                        rdy: 1'b0, ov: 1'b1, idx: 64'd1000, cnt: 4, bsy: 1'b1};
      tbl[5]  = '{vld: '0,                        rdy: 1'b0, ov: 1'b1, idx: 64'd1000, cnt: 4, bsy: 1'b1};
      tbl[6]  = '{vld: '0,                        rdy: 1'b0, ov: 1'b1, idx: 64'd1000, cnt: 4, bsy: 1'b1};
      tbl[7]  = '{vld: '0,                        rdy: 1'b0, ov: 1'b1, idx: 64'd1000, cnt: 4, bsy: 1'b1};
      tbl[8]  = '{vld: '0,                        rdy: 1'b1, ov: 1'b1, idx: 64'd1064, cnt: 4, bsy: 1'b1};
      tbl[9]  = '{vld: '0,                        rdy: 1'b1, ov: 1'b1, idx: 64'd1129, cnt: 4, bsy: 1'b1};
      tbl[10] = '{vld: '0,                        rdy: 1'b1, ov: 1'b0, idx: 64'd0,    cnt: 4, bsy: 1'b0};

      // Reset with every point hitting: nothing may be captured.
      reset = 1'b0;
      applyStimulus('1, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_count", 64'(covered_count), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_index", out_index, 64'd0);

      reset = 1'b1;
      applyStimulus('0, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("rel_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rel_count", 64'(covered_count), 64'd0);
      checkOutput("rel_busy", 64'(busy), 64'd0);

      // Table-driven latency, stall and ordering vectors.
      for (int i = 0; i < 11; i++) begin
         applyStimulus(tbl[i].vld, tbl[i].rdy, 1'b0);
         tick();
         checkOutput($sformatf("row%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
         if (tbl[i].ov) checkOutput($sformatf("row%0d_index", i), out_index, tbl[i].idx);
         checkOutput($sformatf("row%0d_count", i), 64'(covered_count), 64'(tbl[i].cnt));
         checkOutput($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
         checkOutput($sformatf("row%0d_all", i), 64'(all_covered), 64'd0);
      end

      // Repeat hits on bit 7 on three separate cycles.
      xfers.delete();
      for (int p = 0; p < 3; p++) begin
         applyStimulus(hit(7), 1'b1, 1'b0);
         tick();
         applyStimulus('0, 1'b1, 1'b0);
         repeat (4) tick();
      end
      repeat (4) tick();
`ifdef TOGGLE_DRAIN_DEDUP_EN
      expCount = 1;
`else
      expCount = 3;
`endif
      checkOutput("repeat_xfers", 64'(xfers.size()), 64'(expCount));
      orderBad = 0;
      foreach (xfers[k]) if (xfers[k] !== 64'd1007) orderBad++;
      checkOutput("repeat_values", 64'(orderBad), 64'd0);
      checkOutput("repeat_count", 64'(covered_count), 64'd5);

      // Clear together with a hit on bit 7: it counts as fresh again.
      xfers.delete();
      applyStimulus(hit(7), 1'b1, 1'b1);
      tick();
      applyStimulus('0, 1'b1, 1'b0);
      repeat (5) tick();
      checkOutput("clear_xfers", 64'(xfers.size()), 64'd1);
      if (xfers.size() > 0) checkOutput("clear_value", xfers[0], 64'd1007);
      checkOutput("clear_count", 64'(covered_count), 64'd1);

      // Reset while an index is held: out_valid must fall at once.
      xfers.delete();
      applyStimulus(hit(3) | hit(4), 1'b0, 1'b0);
      tick();
      applyStimulus('0, 1'b0, 1'b0);
      tick();
      checkOutput("pre_rst_out_valid", 64'(out_valid), 64'd1);
      checkOutput("pre_rst_index", out_index, 64'd1003);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("async_rst_busy", 64'(busy), 64'd0);
      checkOutput("async_rst_count", 64'(covered_count), 64'd0);
      tick();
      tick();
      reset = 1'b1;
      applyStimulus('0, 1'b1, 1'b0);
      repeat (6) tick();
      checkOutput("post_rst_xfers", 64'(xfers.size()), 64'd0);
      checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);

      // Hit every point at once and drain all of them.
      xfers.delete();
      applyStimulus('1, 1'b1, 1'b0);
      tick();
      checkOutput("all_lag", 64'(all_covered), 64'd0);
      applyStimulus('0, 1'b1, 1'b0);
      tick();
      checkOutput("all_covered", 64'(all_covered), 64'd1);
      checkOutput("all_count", 64'(covered_count), 64'(WIDTH));
      budget = 0;
      while (busy && budget < 400) begin
         tick();
         budget++;
      end
      checkOutput("drain_timeout", 64'(budget < 400), 64'd1);
      tick();
      checkOutput("all_xfers", 64'(xfers.size()), 64'(WIDTH));
      orderBad = 0;
      foreach (xfers[k]) if (xfers[k] !== 64'(BASE + k)) orderBad++;
      checkOutput("all_order", 64'(orderBad), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/toggle_cover_drain.md
Name: toggle_cover_drain

Overview:
- Synthesizable hardware end of the per-bit toggle-cover interface.
- Receives a WIDTH-bit vector of cover-point hit pulses and records which points have ever been hit.
- Streams the absolute index of each newly hit point, COVER_INDEX + bit, over a valid/ready channel to the on-chip coverage uplink.
- Used wherever DPI reporting is unavailable: FPGA prototypes and formal harnesses.

Parameters:
- WIDTH, 130: number of cover points handled by this instance.
- COVER_INDEX, 0: absolute index of bit 0; bit k reports COVER_INDEX + k.
- COVER_TOTAL, 38253: total cover points in the design; used only for the elaboration check COVER_INDEX + WIDTH <= COVER_TOTAL.
- IDX_W, 64: width of the emitted index.

Ports:
- clock, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset (0 = in reset).
- valid, input, WIDTH: per-point hit pulses, sampled every cycle.
- clear, input, 1: synchronous clear of coverage state.
- out_valid, output, 1: index available.
- out_ready, input, 1: consumer accepts index.
- out_index, output, IDX_W: absolute cover index.
- covered_count, output, $clog2(WIDTH+1): number of distinct points hit since reset or clear.
- all_covered, output, 1: covered_count == WIDTH.
- busy, output, 1: pending bitmap non-zero or out_valid high.

Behaviour:
- Reset state (reset low, asynchronous): covered bitmap C = 0, pending bitmap P = 0, out_valid = 0, out_index = 0, covered_count = 0, all_covered = 0, busy = 0. While reset is low, valid is ignored.
- Hit capture, each cycle without clear:
  - new = valid & ~C.
  - C <= C | valid.
  - P <= (P | new) & ~take.
  - take is the one-hot of the lowest set bit of P, non-zero only when the output stage loads.
- Output stage is a holding register. It loads when (!out_valid || out_ready) and P != 0:
  - out_index <= COVER_INDEX + idx(lowest set bit of P), zero-extended to IDX_W.
  - out_valid <= 1.
  - That bit is cleared from P.
- If the stage is free and P == 0: out_valid <= 0.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - out_index is stable while out_valid && !out_ready.
  - out_valid never drops without a transfer, except on reset.
- Ordering and rate:
  - Bits hit in the same cycle are emitted in ascending bit order.
  - Throughput is one index per cycle under continuous out_ready.
- Latency: a hit in cycle n sets P at the end of cycle n. The earliest out_valid with that index is cycle n+2.
- A bit arriving after a lower-priority pending bit was already loaded does not pre-empt it. It waits in P.
- Repeat hits:
  - A hit on a bit already in C, or already in P, generates no additional report.
  - A hit on the bit being loaded in the same cycle is not re-pended, since C is already set.
- clear (synchronous, priority over capture):
  - C <= valid and P <= valid. Hits in the clear cycle count as fresh.
  - The output holding register is unaffected, so an in-flight index still completes its handshake.
- Derived outputs:
  - covered_count is the registered popcount of C, lagging C by one cycle.
  - all_covered is derived from covered_count and therefore also lags C by one cycle.
  - busy = (P != 0) || out_valid, combinational from registers.
- Reset mid-operation: all state is discarded immediately and out_valid falls asynchronously. There is no partial transfer.
- Index arithmetic is unsigned with no wrap; the elaboration check guarantees range.

Optional Feature:
- Macro: TOGGLE_DRAIN_DEDUP_EN.
- Defined: dedup as above; each point is reported at most once between resets or clears.
- Undefined:
  - new = valid, so every hit cycle pends the bit.
  - Hits on a bit already in P coalesce into one report.
  - A bit loaded this cycle and hit this cycle is re-pended.
  - C and covered_count still track distinct points.

Test Plan:
- Reset low with valid = all ones → out_valid = 0, covered_count = 0, busy = 0. Release reset with valid = 0 → outputs stay 0.
- COVER_INDEX = 1000, pulse valid[5] at cycle n, out_ready = 1 → out_valid at n+2, out_index = 1005 for one cycle, covered_count = 1 by n+2.
- Pulse valid[129], valid[0] and valid[64] in one cycle with out_ready = 0 for 5 cycles → out_index is held at 1000 while stalled. Then with out_ready = 1, indices 1000, 1064, 1129 appear on consecutive cycles.
- Dedup (macro defined): pulse valid[7] on three separate cycles → exactly one transfer of 1007. Assert clear, then pulse valid[7] → one more transfer of 1007.
- Macro undefined: pulse valid[7] on cycles 0 and 10 with out_ready = 1 → two transfers of 1007, covered_count = 1.
- Hits on bits 3 and 4, reset asserted while out_valid = 1 → out_valid = 0 immediately, no further transfers after release. All WIDTH bits hit afterwards → all_covered = 1 and 130 transfers.
